// File: rtl/freq_test_engine.sv
// Streaming randomness checker: runs the monobit and block-frequency tests
// in parallel over one N_BITS-long sequence and reports flags plus raw statistics.
module freq_test_engine #(
    parameter int N_BITS     = 128,
    parameter int BLK_LEN    = 16,
    parameter int MONO_LIMIT = 29,
    parameter int BF_LIMIT   = 321,
    localparam int OW = $clog2(N_BITS + 1),
    localparam int CW = $clog2(N_BITS * BLK_LEN + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          bit_in,
    input  logic          bit_valid,
    output logic          bit_ready,
    output logic          busy,
    output logic          done,
    output logic          result_valid,
    output logic          mono_pass,
    output logic          block_pass,
    output logic [OW-1:0] ones_count,
    output logic [CW-1:0] chi_sum
);

    // state   | meaning
    // IDLE    | waiting for start, bit input closed
    // COLLECT | accepting bits, accumulating ones and block statistics
    // EVAL    | single cycle: compare statistics against limits, latch results
    // DONE    | results held until next start
    typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_EVAL, S_DONE} state_t;

    localparam int BW = $clog2(BLK_LEN);
    localparam int KW = $clog2(BLK_LEN + 1) + 1;

    state_t        state, state_nx;
    logic [OW-1:0] bit_cnt, ones;
    logic [BW-1:0] blk_cnt;
    logic [KW-2:0] blk_ones, blk_sum;
    logic [KW-1:0] blk_two, blk_dev;
    logic [CW-1:0] chi_acc, blk_sq;
    logic [OW:0]   two_ones, s_mag;
    logic          accept, last_bit, blk_end, clear_run, mono_ok, block_ok;

    assign clear_run = start && (state != S_EVAL);
    assign accept    = (state == S_COLLECT) && bit_valid && !start;
    assign last_bit  = bit_cnt == OW'(N_BITS - 1);
    assign blk_end   = blk_cnt == BW'(BLK_LEN - 1);

    // Squares and |S| are formed from magnitudes, so no signed arithmetic is needed.
    always_comb begin
        blk_sum  = blk_ones + (KW-1)'(bit_in);
        blk_two  = {blk_sum, 1'b0};
        blk_dev  = (blk_two >= KW'(BLK_LEN)) ? blk_two - KW'(BLK_LEN) : KW'(BLK_LEN) - blk_two;
        blk_sq   = CW'(blk_dev) * CW'(blk_dev);
        two_ones = {ones, 1'b0};
        s_mag    = (two_ones >= (OW+1)'(N_BITS)) ? two_ones - (OW+1)'(N_BITS)
                                                 : (OW+1)'(N_BITS) - two_ones;
        mono_ok  = 32'(s_mag) <= 32'(MONO_LIMIT);
        block_ok = 32'(chi_acc) <= 32'(BF_LIMIT);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx  = state;
        bit_ready = 1'b0;
        busy      = 1'b0;
        case (state)
            S_IDLE, S_DONE: if (start) state_nx = S_COLLECT;
            S_COLLECT: begin
                bit_ready = 1'b1;
                busy      = 1'b1;
                if (accept && last_bit) state_nx = S_EVAL;
            end
            S_EVAL: begin
                busy     = 1'b1;
                state_nx = S_DONE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_cnt      <= '0;
            blk_cnt      <= '0;
            blk_ones     <= '0;
            ones         <= '0;
            chi_acc      <= '0;
            done         <= 1'b0;
            result_valid <= 1'b0;
            mono_pass    <= 1'b0;
            block_pass   <= 1'b0;
            ones_count   <= '0;
            chi_sum      <= '0;
        end else begin
            done <= 1'b0;
            if (clear_run) begin
                bit_cnt      <= '0;
                blk_cnt      <= '0;
                blk_ones     <= '0;
                ones         <= '0;
                chi_acc      <= '0;
                result_valid <= 1'b0;
                mono_pass    <= 1'b0;
                block_pass   <= 1'b0;
            end else if (accept) begin
                ones    <= ones + OW'(bit_in);
                bit_cnt <= bit_cnt + OW'(1);
                blk_cnt <= blk_cnt + BW'(1);
                if (blk_end) begin
                    chi_acc  <= chi_acc + blk_sq;
                    blk_ones <= '0;
                end else begin
                    blk_ones <= blk_sum;
                end
            end else if (state == S_EVAL) begin
                mono_pass    <= mono_ok;
                block_pass   <= block_ok;
                ones_count   <= ones;
                chi_sum      <= chi_acc;
                result_valid <= 1'b1;
                done         <= 1'b1;
            end
        end
    end

endmodule

// File: doc/freq_test_engine.md
Name: freq_test_engine

Overview:
- Parametrised successor to the single-mode monobit test.
- Consumes a serial bit stream under a valid/ready handshake over a sequence of N_BITS bits.
- Evaluates two NIST SP800-22 tests in parallel:
  - Frequency (monobit) test.
  - Block-frequency test over BLK_LEN-bit blocks.
- Reports per-test pass flags and raw statistics. Sits between the pad-level bit input and the tile output mapping.

Parameters:
- N_BITS, 128, sequence length per test run; must be a multiple of BLK_LEN.
- BLK_LEN, 16, block length for the block-frequency test; power of 2, at least 2.
- MONO_LIMIT, 29, monobit pass bound on |2*ones - N_BITS|. Equals floor(2.5758*sqrt(N_BITS)), i.e. p >= 0.01.
- BF_LIMIT, 321, block-frequency pass bound on chi_sum = sum over blocks of (2*c_i - BLK_LEN)^2. Equals floor(chi2crit(0.01, N_BITS/BLK_LEN dof) * BLK_LEN).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request to begin a new run.
- bit_in  in  1  stream bit (epsilon).
- bit_valid  in  1  bit_in is valid this cycle.
- bit_ready  out  1  engine accepts a bit this cycle.
- busy  out  1  run in progress (COLLECT or EVAL).
- done  out  1  one-cycle pulse when results update.
- result_valid  out  1  results are valid; holds until next start.
- mono_pass  out  1  monobit test passed.
- block_pass  out  1  block-frequency test passed.
- ones_count  out  OW  total ones in run; OW = $clog2(N_BITS+1).
- chi_sum  out  CW  block-frequency statistic; CW = $clog2(N_BITS*BLK_LEN+1).

Behaviour:
- Reset: one clock, asynchronous active-high. Asserting rst immediately forces:
  - state IDLE;
  - all counters to 0;
  - all outputs to 0 (bit_ready, busy, done, result_valid, mono_pass, block_pass, ones_count, chi_sum).
- Reset mid-run discards the run. Nothing resumes after rst falls.
- IDLE / DONE states:
  - bit_ready=0; bit_valid is ignored.
  - start moves to COLLECT and clears bit_cnt, blk_cnt, ones, chi_acc, result_valid, mono_pass and block_pass.
- COLLECT state:
  - bit_ready=1 and busy=1.
  - A bit is accepted when bit_valid is high. Idle cycles (bit_valid=0) change nothing.
  - Per accepted bit: ones += bit_in; blk_ones += bit_in; bit_cnt++.
  - When the accepted bit completes a block (blk_cnt == BLK_LEN-1):
    - chi_acc += (2*(blk_ones+bit_in) - BLK_LEN)^2, computed signed with result width CW;
    - blk_ones is cleared.
  - After the N_BITS-th accepted bit, move to EVAL.
  - start during COLLECT aborts and restarts. Counters are cleared, and a bit presented that same cycle is discarded (start wins).
- EVAL state:
  - Lasts one cycle; busy=1, bit_ready=0.
  - Computes S = 2*ones - N_BITS, signed.
  - mono_pass = (|S| <= MONO_LIMIT).
  - block_pass = (chi_acc <= BF_LIMIT).
  - Registers ones_count and chi_sum, then moves to DONE.
  - start is ignored in EVAL.
- DONE state:
  - done=1 for the first cycle only; result_valid=1 until the next start or rst.
  - Results remain stable.
- Latency: done is high in the second cycle after the clock edge that accepted the last bit.
- Width rules:
  - All comparisons are unsigned on magnitudes and do not truncate at the maximum statistic (chi_sum max = N_BITS*BLK_LEN).
  - ones_count can reach N_BITS, so it needs the +1 width.
- Counters never wrap inside a run: bit_cnt terminates at N_BITS and blk_cnt wraps at BLK_LEN.

Test Plan:
- All-zero run, 128 bits with continuous valid -> ones_count=0, mono_pass=0, chi_sum=2048, block_pass=0. done pulses exactly 2 cycles after the last accepted bit.
- Alternating 0101... for 128 bits -> ones_count=64, mono_pass=1, chi_sum=0, block_pass=1, result_valid held high.
- 64 ones followed by 64 zeros -> ones_count=64, mono_pass=1, chi_sum=2048, block_pass=0. Shows the block test catches what monobit misses.
- Monobit boundary, 8 blocks of 16 bits:
  - 7 blocks with 6 ones and 1 with 7 -> ones_count=49, |S|=30, mono_pass=0, chi_sum=116, block_pass=1.
  - 6 blocks with 6 ones and 2 with 7 -> ones_count=50, |S|=28, mono_pass=1, chi_sum=104, block_pass=1.
- Stalls and restart:
  - Random bit_valid gaps over an alternating run give the same result as the gap-free run.
  - start after 70 bits, asserted with bit_valid=1 -> that bit is discarded and the next 128 bits alone determine the results.
- Async reset mid-COLLECT at bit 40 -> all outputs 0 before the next clock edge. After release, bit_ready=0 until start; a subsequent full alternating run passes both tests.
